// File: rtl/divider3_seq_if.sv
// Handshake and operand/result bundle for the sequential 6-by-3 restoring divider.
interface divider3_seq_if;
    logic       start;
    logic [5:0] a;
    logic [2:0] b;
    logic [5:0] q;
    logic [2:0] r;
    logic       busy;
    logic       done;
    logic       dz;

    modport master (
        output start, a, b,
        input  q, r, busy, done, dz
    );

    modport slave (
        input  start, a, b,
        output q, r, busy, done, dz
    );
endinterface

// File: rtl/divider3_seq.sv
// Sequential 6-bit / 3-bit unsigned restoring divider, one quotient bit per clock,
// MSB first, under a start/busy/done handshake.
module divider3_seq (
    input  logic          clk,
    input  logic          rst_n,
    divider3_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [5:0] dvd, dvd_nxt;
    logic [2:0] dvs, dvs_nxt;
    logic [3:0] p, p_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic [5:0] q, q_nxt;
    logic [2:0] r, r_nxt;
    logic       dz, dz_nxt;
    logic [3:0] p_shift;
    logic       q_bit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            dvd   <= '0;
            dvs   <= '0;
            p     <= '0;
            cnt   <= '0;
            q     <= '0;
            r     <= '0;
            dz    <= 1'b0;
        end else begin
            state <= state_nxt;
            dvd   <= dvd_nxt;
            dvs   <= dvs_nxt;
            p     <= p_nxt;
            cnt   <= cnt_nxt;
            q     <= q_nxt;
            r     <= r_nxt;
            dz    <= dz_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dvd_nxt   = dvd;
        dvs_nxt   = dvs;
        p_nxt     = p;
        cnt_nxt   = cnt;
        q_nxt     = q;
        r_nxt     = r;
        dz_nxt    = dz;
        // Bring down the next dividend bit, then trial-subtract the divisor.
        p_shift   = {p[2:0], dvd[5]};
        q_bit     = (p_shift >= {1'b0, dvs});

        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.b == 3'd0) begin
                        q_nxt     = 6'h3F;
                        r_nxt     = 3'd0;
                        dz_nxt    = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        dvd_nxt   = bus.a;
                        dvs_nxt   = bus.b;
                        p_nxt     = 4'd0;
                        cnt_nxt   = 3'd0;
                        dz_nxt    = 1'b0;
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                p_nxt   = q_bit ? (p_shift - {1'b0, dvs}) : p_shift;
                q_nxt   = {q[4:0], q_bit};
                dvd_nxt = {dvd[4:0], 1'b0};
                cnt_nxt = cnt + 3'd1;
                if (cnt == 3'd5) begin
                    // The remainder is below the divisor, so p[3] is zero here.
                    r_nxt     = p_nxt[2:0];
                    state_nxt = DONE;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.q    = q;
    assign bus.r    = r;
    assign bus.dz   = dz;
    assign bus.busy = (state == RUN) || (state == DONE);
    assign bus.done = (state == DONE);

endmodule
